// File: rtl/acc_bank_if.sv
// Request/status bundle for acc_bank: op handshake, read select and registered status.
interface acc_bank_if #(
  parameter int DataWidth = 8,
  parameter int NumAcc    = 4
);
  localparam int SW = $clog2(NumAcc);
  localparam int AW = $clog2(DataWidth);

  logic                 i_valid;
  logic                 o_ready;
  logic [2:0]           i_op;
  logic [SW-1:0]        i_sel;
  logic [AW-1:0]        i_shamt;
  logic [DataWidth-1:0] i_data;
  logic [SW-1:0]        i_rsel;
  logic                 i_ea;
  logic [DataWidth-1:0] o_dataToALU;
  logic                 o_done;
  logic                 o_zero;
  logic                 o_neg;
  logic                 o_carry;

  modport master (
    output i_valid, i_op, i_sel, i_shamt, i_data, i_rsel, i_ea,
    input  o_ready, o_dataToALU, o_done, o_zero, o_neg, o_carry
  );

  modport slave (
    input  i_valid, i_op, i_sel, i_shamt, i_data, i_rsel, i_ea,
    output o_ready, o_dataToALU, o_done, o_zero, o_neg, o_carry
  );
endinterface

// File: rtl/acc_bank.sv
// Bank of accumulators with load/clear/inc/dec and bit-serial shift/rotate,
// a tri-state read bus and a registered ALU read port.
module acc_bank #(
  parameter int DataWidth = 8,
  parameter int NumAcc    = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  acc_bank_if.slave            ctrl,
  output logic [DataWidth-1:0] o_dataToBUS
);
  localparam int SW = $clog2(NumAcc);
  localparam int AW = $clog2(DataWidth);

  localparam logic [2:0] OpNop  = 3'b000;
  localparam logic [2:0] OpLoad = 3'b001;
  localparam logic [2:0] OpClr  = 3'b010;
  localparam logic [2:0] OpInc  = 3'b011;
  localparam logic [2:0] OpDec  = 3'b100;
  localparam logic [2:0] OpShl  = 3'b101;
  localparam logic [2:0] OpShr  = 3'b110;

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e               state_q, state_d;
  logic [DataWidth-1:0] acc_q [NumAcc];
  logic [DataWidth-1:0] acc_d [NumAcc];
  logic [SW-1:0]        sel_q, sel_d;
  logic [2:0]           op_q, op_d;
  logic [AW-1:0]        cnt_q, cnt_d;
  logic [DataWidth-1:0] alu_q;
  logic                 done_q, done_d;
  logic                 zero_q, zero_d;
  logic                 neg_q, neg_d;
  logic                 carry_q, carry_d;

  logic [DataWidth-1:0] result;
  logic                 resCarry;
  logic                 complete;

  // One bit-step of SHL/SHR/ROR; the MSB of the return value is the bit moved out.
  function automatic logic [DataWidth:0] shiftOne(input logic [2:0] op,
                                                  input logic [DataWidth-1:0] v);
    case (op)
      OpShl:   return {v[DataWidth-1], v[DataWidth-2:0], 1'b0};
      OpShr:   return {v[0], 1'b0, v[DataWidth-1:1]};
      default: return {v[0], v[0], v[DataWidth-1:1]};
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    sel_d    = sel_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    zero_d   = zero_q;
    neg_d    = neg_q;
    carry_d  = carry_q;
    result   = '0;
    resCarry = 1'b0;
    complete = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ctrl.i_valid) begin
          sel_d    = ctrl.i_sel;
          op_d     = ctrl.i_op;
          complete = 1'b1;
          case (ctrl.i_op)
            OpNop:  complete = 1'b0;
            OpLoad: result = ctrl.i_data;
            OpClr:  result = '0;
            OpInc: begin
              result   = acc_q[ctrl.i_sel] + DataWidth'(1);
              resCarry = &acc_q[ctrl.i_sel];
            end
            OpDec: begin
              result   = acc_q[ctrl.i_sel] - DataWidth'(1);
              resCarry = ~|acc_q[ctrl.i_sel];
            end
            default: begin
              if (ctrl.i_shamt == '0) begin
                result = acc_q[ctrl.i_sel];
              end else begin
                {resCarry, result} = shiftOne(ctrl.i_op, acc_q[ctrl.i_sel]);
                // The accepting edge is the first step; longer shifts continue in SHIFT.
                if (ctrl.i_shamt != AW'(1)) begin
                  complete = 1'b0;
                  state_d  = SHIFT;
                  cnt_d    = ctrl.i_shamt - AW'(1);
                end
              end
            end
          endcase
          if (ctrl.i_op != OpNop) acc_d[ctrl.i_sel] = result;
        end
      end
      SHIFT: begin
        {resCarry, result} = shiftOne(op_q, acc_q[sel_q]);
        acc_d[sel_q] = result;
        cnt_d        = cnt_q - AW'(1);
        if (cnt_q == AW'(1)) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (complete) begin
      done_d  = 1'b1;
      zero_d  = (result == '0);
      neg_d   = result[DataWidth-1];
      carry_d = resCarry;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      for (int i = 0; i < NumAcc; i++) acc_q[i] <= '0;
      sel_q   <= '0;
      op_q    <= OpNop;
      cnt_q   <= '0;
      alu_q   <= '0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sel_q   <= sel_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      alu_q   <= acc_q[ctrl.i_rsel];
      done_q  <= done_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      carry_q <= carry_d;
    end
  end

  assign ctrl.o_ready     = (state_q == IDLE);
  assign ctrl.o_dataToALU = alu_q;
  assign ctrl.o_done      = done_q;
  assign ctrl.o_zero      = zero_q;
  assign ctrl.o_neg       = neg_q;
  assign ctrl.o_carry     = carry_q;
  assign o_dataToBUS      = ctrl.i_ea ? acc_q[ctrl.i_rsel] : 'z;
endmodule

// File: tb/tb_acc_bank.sv
// Directed and random checks of acc_bank against a whole-operation arithmetic model.
module tb_acc_bank;
  localparam int DW = 8;
  localparam int NA = 4;
  localparam int SW = 2;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst;
  wire [DW-1:0] busData;

  always #5 clk = ~clk;

  acc_bank_if #(.DataWidth(DW), .NumAcc(NA)) ctrl();

  acc_bank #(.DataWidth(DW), .NumAcc(NA)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .ctrl        (ctrl),
    .o_dataToBUS (busData)
  );

  int passCount  = 0;
  int checkCount = 0;
  int failCount  = 0;

  logic [DW-1:0] accM [NA];
  logic zM, nM, cM;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result of shifting v by k positions in one go; MSB of return is the last bit moved out.
  function automatic logic [DW:0] shiftModel(input logic [2:0] op, input logic [DW-1:0] v, input int k);
    logic [2*DW-1:0] w;
    if (k == 0) return {1'b0, v};
    case (op)
      3'd5:    return {v[DW-k], DW'(v << k)};
      3'd6:    return {v[k-1], DW'(v >> k)};
      default: begin
        w = {v, v} >> k;
        return {v[k-1], w[DW-1:0]};
      end
    endcase
  endfunction

  // Issues one op with rsel on the target, follows it to completion and checks the aftermath.
  task automatic applyStimulus(input logic [2:0] op, input logic [SW-1:0] sel,
                               input logic [AW-1:0] shamt, input logic [DW-1:0] data);
    logic [DW-1:0] oldVal, expVal, prevVal;
    logic          expCarry;
    logic [DW:0]   r;
    int            kEdge;
    oldVal = accM[sel];
    kEdge  = (op >= 3'd5 && shamt > 1) ? int'(shamt) : 1;
    case (op)
      3'd0: begin expVal = oldVal; expCarry = cM; end
      3'd1: begin expVal = data;   expCarry = 1'b0; end
      3'd2: begin expVal = '0;     expCarry = 1'b0; end
      3'd3: begin r = {1'b0, oldVal} + 9'd1; expVal = r[DW-1:0]; expCarry = r[DW]; end
      3'd4: begin r = {1'b0, oldVal} - 9'd1; expVal = r[DW-1:0]; expCarry = r[DW]; end
      default: begin r = shiftModel(op, oldVal, int'(shamt)); expVal = r[DW-1:0]; expCarry = r[DW]; end
    endcase
    ctrl.i_op    = op;
    ctrl.i_sel   = sel;
    ctrl.i_shamt = shamt;
    ctrl.i_data  = data;
    ctrl.i_rsel  = sel;
    ctrl.i_ea    = 1'b1;
    ctrl.i_valid = 1'b1;
    for (int e = 1; e <= kEdge; e++) begin
      tick();
      ctrl.i_valid = 1'b0;
      if (e < kEdge) begin
        r = shiftModel(op, oldVal, e);
        checkOutput("shiftReady", ctrl.o_ready, 0);
        checkOutput("shiftDone", ctrl.o_done, 0);
        checkOutput("shiftStep", busData, r[DW-1:0]);
        ctrl.i_valid = 1'($urandom_range(0, 1));
        ctrl.i_sel   = SW'($urandom_range(0, NA-1));
        ctrl.i_op    = 3'($urandom_range(0, 7));
        ctrl.i_shamt = AW'($urandom_range(0, 7));
        ctrl.i_data  = DW'($urandom_range(0, 255));
      end
    end
    ctrl.i_valid = 1'b0;
    if (kEdge > 1) begin
      r = shiftModel(op, oldVal, kEdge - 1);
      prevVal = r[DW-1:0];
    end else begin
      prevVal = oldVal;
    end
    if (op != 3'd0) begin
      accM[sel] = expVal;
      zM = (expVal == '0);
      nM = expVal[DW-1];
      cM = expCarry;
    end
    checkOutput("doneAfterOp", ctrl.o_done, (op != 3'd0) ? 1 : 0);
    checkOutput("readyAfterOp", ctrl.o_ready, 1);
    checkOutput("busAfterOp", busData, accM[sel]);
    checkOutput("aluLagAfterOp", ctrl.o_dataToALU, prevVal);
    checkOutput("zeroFlag", ctrl.o_zero, zM);
    checkOutput("negFlag", ctrl.o_neg, nM);
    checkOutput("carryFlag", ctrl.o_carry, cM);
    tick();
    checkOutput("doneOneCycle", ctrl.o_done, 0);
    checkOutput("aluAfterOp", ctrl.o_dataToALU, accM[sel]);
  endtask

  task automatic checkAllAcc(input string tag);
    ctrl.i_ea = 1'b1;
    for (int i = 0; i < NA; i++) begin
      ctrl.i_rsel = SW'(i);
      #1;
      checkOutput(tag, busData, accM[i]);
    end
  endtask

  initial begin
    $display("[TB] acc_bank bench start");
    rst          = 1'b1;
    ctrl.i_valid = 1'b1;
    ctrl.i_op    = 3'd1;
    ctrl.i_sel   = '0;
    ctrl.i_shamt = '0;
    ctrl.i_data  = 8'h5A;
    ctrl.i_rsel  = '0;
    ctrl.i_ea    = 1'b1;
    for (int i = 0; i < NA; i++) accM[i] = '0;
    zM = 1'b0; nM = 1'b0; cM = 1'b0;
    tick();
    tick();
    rst          = 1'b0;
    ctrl.i_valid = 1'b0;
    checkOutput("rstReady", ctrl.o_ready, 1);
    checkOutput("rstDone", ctrl.o_done, 0);
    checkOutput("rstZero", ctrl.o_zero, 0);
    checkOutput("rstNeg", ctrl.o_neg, 0);
    checkOutput("rstCarry", ctrl.o_carry, 0);
    checkOutput("rstAlu", ctrl.o_dataToALU, 0);
    checkAllAcc("rstBus");

    applyStimulus(3'd1, 2'd2, 3'd0, 8'hA5);
    checkOutput("loadA5", busData, 8'hA5);

    applyStimulus(3'd1, 2'd1, 3'd0, 8'hFF);
    applyStimulus(3'd3, 2'd1, 3'd0, 8'h00);
    checkOutput("incWrap", busData, 8'h00);
    checkOutput("incWrapCarry", ctrl.o_carry, 1);
    applyStimulus(3'd4, 2'd1, 3'd0, 8'h00);
    checkOutput("decWrap", busData, 8'hFF);

    applyStimulus(3'd1, 2'd0, 3'd0, 8'h96);
    applyStimulus(3'd5, 2'd0, 3'd3, 8'h00);
    checkOutput("shl3", busData, 8'hB0);
    checkOutput("shl3Carry", ctrl.o_carry, 0);

    applyStimulus(3'd1, 2'd3, 3'd0, 8'h01);
    applyStimulus(3'd7, 2'd3, 3'd1, 8'h00);
    checkOutput("ror1", busData, 8'h80);
    applyStimulus(3'd7, 2'd3, 3'd0, 8'h00);
    checkOutput("ror0Carry", ctrl.o_carry, 0);

    applyStimulus(3'd1, 2'd0, 3'd0, 8'hFF);
    applyStimulus(3'd6, 2'd0, 3'd7, 8'h00);
    checkOutput("shr7", busData, 8'h01);
    applyStimulus(3'd0, 2'd0, 3'd0, 8'h00);

    for (int n = 0; n < 40; n++) begin
      applyStimulus(3'($urandom_range(0, 7)), SW'($urandom_range(0, NA-1)),
                    AW'($urandom_range(0, 7)), DW'($urandom_range(0, 255)));
    end
    tick();
    checkAllAcc("randomFinal");

    // A shift interrupted by reset is dropped without a completion pulse.
    applyStimulus(3'd1, 2'd0, 3'd0, 8'hFF);
    applyStimulus(3'd1, 2'd2, 3'd0, 8'h3C);
    ctrl.i_op    = 3'd6;
    ctrl.i_sel   = 2'd0;
    ctrl.i_shamt = 3'd7;
    ctrl.i_rsel  = 2'd0;
    ctrl.i_valid = 1'b1;
    tick();
    ctrl.i_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NA; i++) accM[i] = '0;
    zM = 1'b0; nM = 1'b0; cM = 1'b0;
    checkOutput("midRstReady", ctrl.o_ready, 1);
    checkOutput("midRstDone", ctrl.o_done, 0);
    checkOutput("midRstAlu", ctrl.o_dataToALU, 0);
    checkOutput("midRstCarry", ctrl.o_carry, 0);
    checkOutput("midRstNeg", ctrl.o_neg, 0);
    checkAllAcc("midRstBus");
    tick();
    checkOutput("midRstNoDone", ctrl.o_done, 0);
    checkOutput("midRstReady2", ctrl.o_ready, 1);

    for (int i = 0; i < NA; i++) begin
      applyStimulus(3'd1, SW'(i), 3'd0, DW'($urandom_range(0, 255)) | 8'h01);
    end
    ctrl.i_ea = 1'b0;
    for (int i = 0; i < NA; i++) begin
      ctrl.i_rsel = SW'(i);
      #1;
      checkOutput("busUndriven", (busData === accM[i]) ? 1 : 0, 0);
      if (i > 0) checkOutput("aluStillOld", ctrl.o_dataToALU, accM[i-1]);
      tick();
      checkOutput("aluFollows", ctrl.o_dataToALU, accM[i]);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
